// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder: format classes, ALU op codes,
// opcodes, funct3/funct7 values and reject codes.
package rv_isa_pkg;

  typedef enum logic [3:0] {
    FmtR      = 4'd0,
    FmtI      = 4'd1,
    FmtLoad   = 4'd2,
    FmtStore  = 4'd3,
    FmtBranch = 4'd4,
    FmtJal    = 4'd5,
    FmtJalr   = 4'd6,
    FmtLui    = 4'd7,
    FmtAuipc  = 4'd8
  } fmt_e;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluSll  = 4'b0010;
  localparam logic [3:0] AluSlt  = 4'b0011;
  localparam logic [3:0] AluSltu = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluOr   = 4'b1000;
  localparam logic [3:0] AluAnd  = 4'b1001;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [2:0] F3Add  = 3'b000;
  localparam logic [2:0] F3Sll  = 3'b001;
  localparam logic [2:0] F3Slt  = 3'b010;
  localparam logic [2:0] F3Sltu = 3'b011;
  localparam logic [2:0] F3Xor  = 3'b100;
  localparam logic [2:0] F3Sr   = 3'b101;
  localparam logic [2:0] F3Or   = 3'b110;
  localparam logic [2:0] F3And  = 3'b111;
  localparam logic [2:0] F3Jalr = 3'b000;

  localparam logic [6:0] Funct7Zero = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  typedef enum logic [1:0] {
    ErrNone    = 2'b00,
    ErrIllegal = 2'b01,
    ErrFunct3  = 2'b10,
    ErrImm     = 2'b11
  } err_e;

  function automatic logic [2:0] alu_funct3(input logic [3:0] op);
    logic [2:0] f3;
    case (op)
      AluAdd, AluSub: f3 = F3Add;
      AluSll:         f3 = F3Sll;
      AluSlt:         f3 = F3Slt;
      AluSltu:        f3 = F3Sltu;
      AluXor:         f3 = F3Xor;
      AluSrl, AluSra: f3 = F3Sr;
      AluOr:          f3 = F3Or;
      AluAnd:         f3 = F3And;
      default:        f3 = F3Add;
    endcase
    return f3;
  endfunction

  function automatic logic alu_is_alt(input logic [3:0] op);
    return (op == AluSub) || (op == AluSra);
  endfunction

  function automatic logic alu_is_shift(input logic [3:0] op);
    return (op == AluSll) || (op == AluSrl) || (op == AluSra);
  endfunction

endpackage

// File: rtl/insn_field_pack.sv
// Combinational packer: decoded fields to a 32-bit RV32I word plus a reject code.
// Define IMM_RANGE_CHECK_EN to reject out-of-range or misaligned immediates instead of truncating.
module insn_field_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  fmt,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err,
  output err_e        code
);

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  logic       alu_ok;
  logic       alu_alt;
  logic       alu_shift;
  logic [2:0] alu_f3;
  logic       fits_i;
  logic       fits_b;
  logic       fits_j;

  assign alu_ok    = (alu_op <= AluAnd);
  assign alu_alt   = alu_is_alt(alu_op);
  assign alu_shift = alu_is_shift(alu_op);
  assign alu_f3    = alu_funct3(alu_op);

  // Sign-extension checks: all bits above the field's sign bit must match it.
  assign fits_i = (imm[31:11] == '0) || (&imm[31:11]);
  assign fits_b = ((imm[31:12] == '0) || (&imm[31:12])) && !imm[0];
  assign fits_j = ((imm[31:20] == '0) || (&imm[31:20])) && !imm[0];

  always_comb begin
    word = '0;
    code = ErrNone;
    case (fmt)
      FmtR: begin
        if (!alu_ok) code = ErrIllegal;
        word = {alu_alt ? Funct7Alt : Funct7Zero, rs2, rs1, alu_f3, rd, OpcR};
      end
      FmtI: begin
        if (!alu_ok || (alu_op == AluSub)) begin
          code = ErrIllegal;
        end else if (RangeCheck && (alu_shift ? (imm[11:5] != '0) : !fits_i)) begin
          code = ErrImm;
        end
        if (alu_shift) begin
          word = {(alu_op == AluSra) ? Funct7Alt : Funct7Zero, imm[4:0], rs1, alu_f3, rd, OpcI};
        end else begin
          word = {imm[11:0], rs1, alu_f3, rd, OpcI};
        end
      end
      FmtLoad: begin
        if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) begin
          code = ErrFunct3;
        end else if (RangeCheck && !fits_i) begin
          code = ErrImm;
        end
        word = {imm[11:0], rs1, funct3, rd, OpcLoad};
      end
      FmtStore: begin
        if (funct3 >= 3'b011) begin
          code = ErrFunct3;
        end else if (RangeCheck && !fits_i) begin
          code = ErrImm;
        end
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpcStore};
      end
      FmtBranch: begin
        if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
          code = ErrFunct3;
        end else if (RangeCheck && !fits_b) begin
          code = ErrImm;
        end
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpcBranch};
      end
      FmtJal: begin
        if (RangeCheck && !fits_j) code = ErrImm;
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
      end
      FmtJalr: begin
        if (funct3 != F3Jalr) begin
          code = ErrFunct3;
        end else if (RangeCheck && !fits_i) begin
          code = ErrImm;
        end
        word = {imm[11:0], rs1, F3Jalr, rd, OpcJalr};
      end
      FmtLui: begin
        word = {imm[31:12], rd, OpcLui};
      end
      FmtAuipc: begin
        word = {imm[31:12], rd, OpcAuipc};
      end
      default: begin
        code = ErrIllegal;
      end
    endcase
  end

  assign err = (code != ErrNone);

endmodule

// File: rtl/insn_encoder.sv
// Streaming RV32I encoder: one-deep output register toward instruction memory with an
// auto-incrementing word address, write counter and one-cycle reject pulse.
module insn_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic [3:0]        i_fmt,
  input  logic [3:0]        i_alu_op,
  input  logic [2:0]        i_funct3,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [31:0]       i_imm,
  input  logic              i_addr_load,
  input  logic [ADDR_W-1:0] i_addr_val,
  output logic              o_wr_vld,
  input  logic              i_wr_rdy,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [15:0]       o_count
);

  localparam logic [ADDR_W-1:0] AddrMask = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR) & AddrMask;

  logic [31:0]       pack_word;
  logic              pack_err;
  err_e              pack_code;

  logic              wr_vld_q;
  logic [31:0]       wr_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic              accept;
  logic              wr_hs;

  insn_field_pack u_pack (
    .fmt    (i_fmt),
    .alu_op (i_alu_op),
    .funct3 (i_funct3),
    .rd     (i_rd),
    .rs1    (i_rs1),
    .rs2    (i_rs2),
    .imm    (i_imm),
    .word   (pack_word),
    .err    (pack_err),
    .code   (pack_code)
  );

  assign o_req_rdy = ~wr_vld_q | i_wr_rdy;
  assign accept    = i_req_vld & o_req_rdy;
  assign wr_hs     = wr_vld_q & i_wr_rdy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_vld_q   <= 1'b0;
      wr_data_q  <= '0;
      addr_q     <= BaseAddr;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      // A rejected request only completes alongside a draining word, so clearing valid is safe.
      if (accept && !pack_err) begin
        wr_vld_q  <= 1'b1;
        wr_data_q <= pack_word;
      end else if (wr_hs) begin
        wr_vld_q <= 1'b0;
      end

      err_q <= accept & pack_err;
      if (accept && pack_err) err_code_q <= pack_code;

      if (i_addr_load) begin
        addr_q <= i_addr_val & AddrMask;
      end else if (wr_hs) begin
        addr_q <= addr_q + ADDR_W'(4);
      end

      if (wr_hs && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
    end
  end

  assign o_wr_vld   = wr_vld_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_addr  = addr_q;
  assign o_err      = err_q;
  assign o_err_code = err_code_q;
  assign o_count    = count_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder; immediate-range expectations follow IMM_RANGE_CHECK_EN.
module tb_insn_encoder;
  import rv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_vld;
  logic        req_rdy;
  logic [3:0]  fmt;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        addr_load;
  logic [11:0] addr_val;
  logic        wr_vld;
  logic        wr_rdy;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;
  int exp_count;

  insn_encoder #(
    .ADDR_W    (12),
    .BASE_ADDR (0)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_vld   (req_vld),
    .o_req_rdy   (req_rdy),
    .i_fmt       (fmt),
    .i_alu_op    (alu_op),
    .i_funct3    (funct3),
    .i_rd        (rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_imm       (imm),
    .i_addr_load (addr_load),
    .i_addr_val  (addr_val),
    .o_wr_vld    (wr_vld),
    .i_wr_rdy    (wr_rdy),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_err       (err),
    .o_err_code  (err_code),
    .o_count     (count)
  );

  always #5 clk = ~clk;

  task automatic set_req(input logic [3:0] f, input logic [3:0] op, input logic [2:0] f3,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [31:0] im);
    fmt = f; alu_op = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
    req_vld = 1'b1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] op, input logic [2:0] f3,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    set_req(f, op, f3, d, s1, s2, im);
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_vld = 1'b0; addr_load = 1'b0; addr_val = '0; wr_rdy = 1'b1;
    set_req(4'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    req_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", wr_vld); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++;
    if (err_code !== 2'b00) begin bad++; $display("FAIL rst_code got=%b want=00", err_code); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (wr_addr !== 12'h000) begin bad++; $display("FAIL rst_addr got=%h want=000", wr_addr); end
    total++;
    if (wr_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=00000000", wr_data); end
    total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b want=1", req_rdy); end
  endtask

  task automatic test_r_type;
    issue(FmtR, AluAdd, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    total++; if (wr_vld !== 1'b1) begin bad++; $display("FAIL add_vld got=%b want=1", wr_vld); end
    total++;
    if (wr_data !== 32'h002081B3) begin bad++; $display("FAIL add_data got=%h want=002081b3", wr_data); end
    total++; if (wr_addr !== 12'h000) begin bad++; $display("FAIL add_addr got=%h want=000", wr_addr); end
    issue(FmtR, AluSub, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    total++;
    if (wr_data !== 32'h402081B3) begin bad++; $display("FAIL sub_data got=%h want=402081b3", wr_data); end
    total++; if (wr_addr !== 12'h004) begin bad++; $display("FAIL sub_addr got=%h want=004", wr_addr); end
    @(posedge clk); #1;
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL r_drain_vld got=%b want=0", wr_vld); end
    total++; if (count !== 16'd2) begin bad++; $display("FAIL r_count got=%0d want=2", count); end
    total++; if (wr_addr !== 12'h008) begin bad++; $display("FAIL r_addr got=%h want=008", wr_addr); end
  endtask

  task automatic test_i_u;
    issue(FmtI, AluSra, 3'd0, 5'd5, 5'd6, 5'd0, 32'd3);
    total++;
    if (wr_data !== 32'h40335293) begin bad++; $display("FAIL srai_data got=%h want=40335293", wr_data); end
    total++; if (wr_addr !== 12'h008) begin bad++; $display("FAIL srai_addr got=%h want=008", wr_addr); end
    issue(FmtLui, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    total++;
    if (wr_data !== 32'h123452B7) begin bad++; $display("FAIL lui_data got=%h want=123452b7", wr_data); end
    total++; if (wr_addr !== 12'h00C) begin bad++; $display("FAIL lui_addr got=%h want=00c", wr_addr); end
    @(posedge clk); #1;
    total++; if (count !== 16'd4) begin bad++; $display("FAIL iu_count got=%0d want=4", count); end
  endtask

  task automatic test_branch_jal;
    issue(FmtBranch, 4'd0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8);
    total++;
    if (wr_data !== 32'h00208463) begin bad++; $display("FAIL beq_data got=%h want=00208463", wr_data); end
    total++; if (wr_addr !== 12'h010) begin bad++; $display("FAIL beq_addr got=%h want=010", wr_addr); end
    issue(FmtJal, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16);
    total++;
    if (wr_data !== 32'h010000EF) begin bad++; $display("FAIL jal_data got=%h want=010000ef", wr_data); end
    total++; if (wr_addr !== 12'h014) begin bad++; $display("FAIL jal_addr got=%h want=014", wr_addr); end
    @(posedge clk); #1;
    total++; if (count !== 16'd6) begin bad++; $display("FAIL bj_count got=%0d want=6", count); end
    total++; if (wr_addr !== 12'h018) begin bad++; $display("FAIL bj_addr got=%h want=018", wr_addr); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] stream_data [4];
    stream_data[0] = 32'h00700193;
    stream_data[1] = 32'h00800213;
    stream_data[2] = 32'h00900293;
    stream_data[3] = 32'h00A00313;
    wr_rdy = 1'b0;
    issue(FmtI, AluAdd, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    set_req(FmtI, AluAdd, 3'd0, 5'd2, 5'd0, 5'd0, 32'd6);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_data !== 32'h00500093) begin
        bad++; $display("FAIL stall_data[%0d] got=%h want=00500093", i, wr_data);
      end
      total++;
      if (wr_addr !== 12'h018) begin bad++; $display("FAIL stall_addr[%0d] got=%h want=018", i, wr_addr); end
      total++;
      if (req_rdy !== 1'b0) begin bad++; $display("FAIL stall_rdy[%0d] got=%b want=0", i, req_rdy); end
      total++;
      if (count !== 16'd6) begin bad++; $display("FAIL stall_count[%0d] got=%0d want=6", i, count); end
      @(posedge clk); #1;
    end
    wr_rdy = 1'b1;
    @(posedge clk); #1;
    total++;
    if (wr_data !== 32'h00600113) begin bad++; $display("FAIL rel_data got=%h want=00600113", wr_data); end
    total++; if (wr_addr !== 12'h01C) begin bad++; $display("FAIL rel_addr got=%h want=01c", wr_addr); end
    total++; if (count !== 16'd7) begin bad++; $display("FAIL rel_count got=%0d want=7", count); end
    for (int i = 0; i < 4; i++) begin
      set_req(FmtI, AluAdd, 3'd0, 5'(3 + i), 5'd0, 5'd0, 32'(7 + i));
      @(posedge clk); #1;
      total++;
      if (wr_data !== stream_data[i]) begin
        bad++; $display("FAIL strm_data[%0d] got=%h want=%h", i, wr_data, stream_data[i]);
      end
      total++;
      if (wr_addr !== 12'(32'h20 + 4 * i)) begin
        bad++; $display("FAIL strm_addr[%0d] got=%h want=%h", i, wr_addr, 12'(32'h20 + 4 * i));
      end
    end
    req_vld = 1'b0;
    @(posedge clk); #1;
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL strm_vld got=%b want=0", wr_vld); end
    total++; if (count !== 16'd12) begin bad++; $display("FAIL strm_count got=%0d want=12", count); end
    total++; if (wr_addr !== 12'h030) begin bad++; $display("FAIL strm_addr got=%h want=030", wr_addr); end
  endtask

  task automatic test_errors;
    issue(FmtI, AluAdd, 3'd0, 5'd7, 5'd0, 5'd0, 32'd1);
    total++;
    if (wr_data !== 32'h00100393) begin bad++; $display("FAIL pre_data got=%h want=00100393", wr_data); end
    // Rejected SUBI arrives while the ADDI drains.
    issue(FmtI, AluSub, 3'd0, 5'd1, 5'd1, 5'd0, 32'd0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL subi_err got=%b want=1", err); end
    total++;
    if (err_code !== 2'b01) begin bad++; $display("FAIL subi_code got=%b want=01", err_code); end
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL subi_vld got=%b want=0", wr_vld); end
    total++; if (wr_addr !== 12'h034) begin bad++; $display("FAIL subi_addr got=%h want=034", wr_addr); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL subi_pulse got=%b want=0", err); end
    total++;
    if (err_code !== 2'b01) begin bad++; $display("FAIL subi_hold got=%b want=01", err_code); end
    total++; if (count !== 16'd13) begin bad++; $display("FAIL subi_count got=%0d want=13", count); end
    issue(FmtStore, 4'd0, 3'b011, 5'd0, 5'd1, 5'd2, 32'd0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL st3_err got=%b want=1", err); end
    total++;
    if (err_code !== 2'b10) begin bad++; $display("FAIL st3_code got=%b want=10", err_code); end
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL st3_vld got=%b want=0", wr_vld); end
    issue(4'd9, AluAdd, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    total++;
    if (err_code !== 2'b01) begin bad++; $display("FAIL fmt9_code got=%b want=01", err_code); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL fmt9_pulse got=%b want=0", err); end
    total++; if (wr_addr !== 12'h034) begin bad++; $display("FAIL err_addr got=%h want=034", wr_addr); end
    exp_count = 13;
  endtask

  task automatic test_imm_range;
`ifdef IMM_RANGE_CHECK_EN
    issue(FmtI, AluAdd, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL addi2048_err got=%b want=1", err); end
    total++;
    if (err_code !== 2'b11) begin bad++; $display("FAIL addi2048_code got=%b want=11", err_code); end
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL addi2048_vld got=%b want=0", wr_vld); end
    issue(FmtBranch, 4'd0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd7);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL b7_err got=%b want=1", err); end
    total++;
    if (err_code !== 2'b11) begin bad++; $display("FAIL b7_code got=%b want=11", err_code); end
`else
    issue(FmtI, AluAdd, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    total++;
    if (wr_data !== 32'h80000093) begin bad++; $display("FAIL addi2048_data got=%h want=80000093", wr_data); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL addi2048_err got=%b want=0", err); end
    issue(FmtBranch, 4'd0, 3'b000, 5'd0, 5'd1, 5'd2, 32'd7);
    total++;
    if (wr_data !== 32'h00208363) begin bad++; $display("FAIL b7_data got=%h want=00208363", wr_data); end
    total++; if (wr_addr !== 12'h038) begin bad++; $display("FAIL b7_addr got=%h want=038", wr_addr); end
    exp_count = exp_count + 2;
`endif
    @(posedge clk); #1;
    total++;
    if (count !== 16'(exp_count)) begin bad++; $display("FAIL imm_count got=%0d want=%0d", count, exp_count); end
  endtask

  task automatic test_addr_load;
    addr_load = 1'b1; addr_val = 12'h103;
    @(posedge clk); #1;
    addr_load = 1'b0;
    total++; if (wr_addr !== 12'h100) begin bad++; $display("FAIL ld_addr got=%h want=100", wr_addr); end
    wr_rdy = 1'b0;
    issue(FmtI, AluAdd, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    addr_load = 1'b1; addr_val = 12'h200;
    @(posedge clk); #1;
    addr_load = 1'b0;
    total++; if (wr_addr !== 12'h200) begin bad++; $display("FAIL ldp_addr got=%h want=200", wr_addr); end
    total++;
    if (wr_data !== 32'h00500093) begin bad++; $display("FAIL ldp_data got=%h want=00500093", wr_data); end
    total++; if (wr_vld !== 1'b1) begin bad++; $display("FAIL ldp_vld got=%b want=1", wr_vld); end
    // Load and write handshake in the same cycle: the load takes the address.
    wr_rdy = 1'b1; addr_load = 1'b1; addr_val = 12'h302;
    @(posedge clk); #1;
    addr_load = 1'b0;
    exp_count = exp_count + 1;
    total++; if (wr_addr !== 12'h300) begin bad++; $display("FAIL ldhs_addr got=%h want=300", wr_addr); end
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL ldhs_vld got=%b want=0", wr_vld); end
    total++;
    if (count !== 16'(exp_count)) begin bad++; $display("FAIL ldhs_count got=%0d want=%0d", count, exp_count); end
  endtask

  task automatic test_reset_mid;
    wr_rdy = 1'b0;
    issue(FmtI, AluAdd, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr_rdy = 1'b1;
    total++; if (wr_vld !== 1'b0) begin bad++; $display("FAIL mid_vld got=%b want=0", wr_vld); end
    total++; if (wr_addr !== 12'h000) begin bad++; $display("FAIL mid_addr got=%h want=000", wr_addr); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
    total++;
    if (wr_data !== 32'h0) begin bad++; $display("FAIL mid_data got=%h want=00000000", wr_data); end
  endtask

  initial begin
    test_reset;
    test_r_type;
    test_i_u;
    test_branch_jal;
    test_back_to_back;
    test_errors;
    test_imm_range;
    test_addr_load;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
